// File: rtl/disp_scan_ctrl_if.sv
// disp_scan_ctrl_if: source/config inputs and digit-drive outputs of the display scan controller
interface disp_scan_ctrl_if;
  logic        enable;
  logic [31:0] data_in;
  logic [1:0]  page_mode;
  logic [3:0]  dp_mask;
  logic [3:0]  LEDSEL;
  logic [7:0]  LEDOUT;
  logic        page_out;
  logic        frame_tick;
  modport master (output enable, data_in, page_mode, dp_mask, input LEDSEL, LEDOUT, page_out, frame_tick);
  modport slave (input enable, data_in, page_mode, dp_mask, output LEDSEL, LEDOUT, page_out, frame_tick);
endinterface

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit 7-segment scan with blanking gaps, frame-coherent snapshot and page rotation
// Define LZ_BLANK_EN to suppress leading zeros on digits 3..1.
module disp_scan_ctrl #(
  parameter int DWELL_CYC   = 5,
  parameter int BLANK_CYC   = 1,
  parameter int PAGE_FRAMES = 800
) (
  input logic clk,
  input logic rst,
  disp_scan_ctrl_if.slave bus
);
  localparam int CMAX = DWELL_CYC > BLANK_CYC ? DWELL_CYC : BLANK_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam int FW = $clog2(PAGE_FRAMES + 1);
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef enum logic [1:0] {IDLE, LOAD, DRIVE, BLANK} state_t;
  state_t state, ns;
  logic [1:0] digit, ndig;
  logic [CW-1:0] cnt, ncnt;
  logic [FW-1:0] fcnt;
  logic [31:0] snap;
  logic [15:0] cur;
  logic [3:0] nib;
  logic last, lz;
  always_comb begin
    ns = state;
    ndig = digit;
    ncnt = '0;
    last = state == DRIVE ? cnt == CW'(DWELL_CYC - 1) : cnt == CW'(BLANK_CYC - 1);
    if (!bus.enable) ns = IDLE;
    else if (state == IDLE) ns = LOAD;
    else if (state == LOAD) begin
      ns = DRIVE;
      ndig = '0;
    end else if (!last) ncnt = cnt + 1'b1;
    else if (state == DRIVE && BLANK_CYC != 0) ns = BLANK;
    else begin
      ns = digit == 2'd3 ? LOAD : DRIVE;
      ndig = digit + 2'd1;
    end
    // Output registers are loaded from the next state, so snapshot/page are already valid here
    cur = bus.page_out ? snap[31:16] : snap[15:0];
    nib = cur[{ndig, 2'b00} +: 4];
`ifdef LZ_BLANK_EN
    lz = ndig != 2'd0 && (cur >> {ndig, 2'b00}) == 16'h0;
`else
    lz = 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      digit <= '0;
      cnt <= '0;
      fcnt <= '0;
      snap <= '0;
      bus.page_out <= 1'b0;
      bus.LEDSEL <= 4'hF;
      bus.LEDOUT <= 8'hFF;
      bus.frame_tick <= 1'b0;
    end else begin
      state <= ns;
      digit <= ndig;
      cnt <= ncnt;
      bus.LEDSEL <= ns == DRIVE ? ~(4'b0001 << ndig) : 4'hF;
      bus.LEDOUT <= ns == DRIVE ? {~bus.dp_mask[ndig], lz ? 7'h7F : SEG[nib]} : 8'hFF;
      bus.frame_tick <= ns == DRIVE && ndig == 2'd3 && ncnt == CW'(DWELL_CYC - 1);
      if (ns == LOAD) begin
        snap <= bus.data_in;
        if (!bus.page_mode[1]) begin
          bus.page_out <= bus.page_mode[0];
          fcnt <= '0;
        end else if (fcnt >= FW'(PAGE_FRAMES)) begin
          bus.page_out <= ~bus.page_out;
          fcnt <= FW'(1);
        end else fcnt <= fcnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's 4-digit common-anode 7-segment display. It snapshots a 32-bit value from the SoC's GPO2 register and selects which 16-bit half (page) to show. It then drives one digit at a time, inserting a blanking gap between digits to suppress ghosting. This replaces the free-running digit mux and the static half-select mux in the board top, and adds automatic page rotation and frame-coherent updates.

Parameters:
DWELL_CYC, 5, clk cycles each digit is driven (min 1)
BLANK_CYC, 1, clk cycles all digits are off between digits (0 = no gap)
PAGE_FRAMES, 800, complete frames per page in auto mode (min 1)

Ports:
clk  input  1  scan clock (5 kHz board clock)
rst  input  1  asynchronous active-low reset
enable  input  1  1 = scanning; 0 = display dark, FSM held in IDLE
data_in  input  32  display source (gpo2); [15:0] is page 0, [31:16] is page 1
page_mode  input  2  00 = page 0 fixed, 01 = page 1 fixed, 1x = auto-rotate
dp_mask  input  4  decimal-point enable per digit, bit i = digit i
LEDSEL  output  4  digit enables, active-low, one-cold; bit 0 = rightmost digit
LEDOUT  output  8  segments, active-low, order {dp,g,f,e,d,c,b,a}
page_out  output  1  page currently displayed
frame_tick  output  1  one-cycle pulse when digit 3's dwell completes

Behaviour:
- Reset (rst=0, async): FSM=IDLE, digit index=0, dwell/blank counters=0, frame counter=0, page_out=0, snapshot=0, LEDSEL=4'hF, LEDOUT=8'hFF, frame_tick=0.
- All outputs are registered. LEDSEL and LEDOUT update on the same edge and are never driven from different digits in the same cycle.
- FSM states:
  - IDLE: display dark. If enable=1, next cycle goes to LOAD.
  - LOAD: one cycle. Latches snapshot<=data_in. Resolves page (see page rules). Sets digit=0. Goes to DRIVE. Display dark.
  - DRIVE: LEDSEL = ~(1<<digit). LEDOUT = decode(nibble[digit]) with dp active if dp_mask[digit]. Lasts exactly DWELL_CYC cycles.
  - BLANK: LEDSEL=4'hF, LEDOUT=8'hFF for BLANK_CYC cycles. If BLANK_CYC=0, this state is skipped.
- After DRIVE:
  - digit<3: go to BLANK (or skip it), then digit+1, then DRIVE.
  - digit=3: assert frame_tick for one cycle on the last DRIVE cycle, then go to BLANK (or skip it), then LOAD. The frame wraps to digit 0.
- Frame length is 4*(DWELL_CYC+BLANK_CYC)+1 cycles, including LOAD.
- Snapshot coherence: data_in changes mid-frame are invisible until the next LOAD. The same rule applies to page_mode changes. dp_mask is sampled live.
- Page rules, evaluated in LOAD only:
  - Mode 00 forces page 0 and resets the frame counter.
  - Mode 01 forces page 1 and resets the frame counter.
  - Mode 1x: the frame counter increments each frame. When it reaches PAGE_FRAMES, page toggles and the counter clears.
  - Entering auto mode starts from the currently shown page.
- enable deasserted in any state: next edge goes to IDLE and blanks the display. The digit index and frame counter are kept; the page counter is not cleared. Re-enable restarts at LOAD with digit 0.
- Hex decode, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - dp bit (bit7) = 0 when lit.
- Counter widths: $clog2(max+1) each. No counter may overflow for any legal parameter value.

Optional Feature:
LZ_BLANK_EN
- Defined: leading-zero suppression. Digit i (i=3..1) is blanked when its nibble and all higher nibbles of the current page are 0. LEDOUT=8'hFF except the dp bit, which still follows dp_mask. LEDSEL still selects the digit so timing is unchanged. Digit 0 is always shown.
- Undefined: all four digits always display their nibble.

Test Plan:
1. DWELL_CYC=4, BLANK_CYC=1, mode 00, data_in=32'h0000_1A3F, enable=1 after reset.
   -> LEDSEL sequence E,F,D,F,B,F,7,F with 4/1-cycle durations.
   -> LEDOUT 0E (F), 30 (3), 08 (A), 79 (1).
   -> frame_tick every 21 cycles.
2. Change data_in to 32'h0000_2222 while digit 1 is displayed.
   -> digits 2 and 3 still show A and 1.
   -> 2 (LEDOUT=24) first appears at the next frame's digit 0.
3. PAGE_FRAMES=2, mode 10, data_in=32'hBEEF_CAFE.
   -> frames show CAFE, CAFE, BEEF, BEEF, CAFE; page_out toggles at frames 3 and 5.
   -> Switching to mode 01 takes effect at the next LOAD.
4. Drop enable mid-DRIVE of digit 2.
   -> next edge LEDSEL=F, LEDOUT=FF.
   -> re-enable: one dark LOAD cycle, then digit 0 drives.
5. Assert rst=0 asynchronously mid-BLANK.
   -> outputs go to reset values immediately without a clock edge.
   -> dp_mask=4'b0100 lights only digit 2's dp (LEDOUT[7]=0).
6. LZ_BLANK_EN defined, data_in[15:0]=16'h0050.
   -> digit 3 blank (FF), digit 2 blank, digit 1 shows 12 (5), digit 0 shows 40 (0).
   -> with 16'h0000, only digit 0 is lit.
